// File: rtl/cache_def.sv
// ------------------------------------------------------------------
// cache_def: shared cache/memory datapath types
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package cache_def;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

endpackage

`default_nettype wire

// File: rtl/mem_ctrl_downstream_pkg.sv
// ------------------------------------------------------------------
// mem_ctrl_downstream_pkg: controller state encoding and helpers
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_ctrl_downstream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } mem_state_e;

  // Wide enough for the largest legal LATENCY of 15.
  localparam int CNT_W = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hffff) ? value : value + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl_downstream_if.sv
// ------------------------------------------------------------------
// mem_ctrl_downstream_if: cache <-> memory request/response bundle
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

interface mem_ctrl_downstream_if;
  import cache_def::*;

  mem_req_type  mem_req;
  mem_data_type mem_data;

  modport master (output mem_req, input mem_data);
  modport slave  (input mem_req, output mem_data);

endinterface

`default_nettype wire

// File: rtl/mem_store_downstream.sv
// ------------------------------------------------------------------
// mem_store_downstream: backing line array, 1 write + 1 registered read
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_store_downstream
  import cache_def::*;
#(
  parameter int LINES_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LINES_LOG2-1:0] waddr,
  input  cache_data_type        wdata,
  input  logic                  re,
  input  logic [LINES_LOG2-1:0] raddr,
  output cache_data_type        rdata
);

  // Contents survive reset; only elaboration clears them.
  cache_data_type mem [2**LINES_LOG2] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_ctrl_downstream.sv
// ------------------------------------------------------------------
// mem_ctrl_downstream: fixed-latency memory model behind the cache
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_ctrl_downstream
  import cache_def::*;
  import mem_ctrl_downstream_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int LINES_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_ctrl_downstream_if.slave  bus,
  output logic                  busy,
  output logic [15:0]           rd_cnt,
  output logic [15:0]           wr_cnt
);

  mem_state_e            state;
  mem_state_e            state_next;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  accept;
  logic                  enter_resp;

  logic [LINES_LOG2-1:0] req_idx;
  logic [LINES_LOG2-1:0] hold_idx;
  cache_data_type        hold_data;
  logic                  hold_rw;
  logic [LINES_LOG2-1:0] eff_idx;
  cache_data_type        eff_data;
  logic                  eff_rw;

  logic                  store_we;
  logic                  store_re;
  cache_data_type        store_rdata;
  cache_data_type        wr_line;
  logic                  resp_from_store;
  logic                  unused_addr;

  assign req_idx     = bus.mem_req.addr[LINES_LOG2+3:4];
  assign unused_addr = ^{bus.mem_req.addr[31:LINES_LOG2+4], bus.mem_req.addr[3:0]};
  assign accept      = bus.mem_req.valid && (state == IDLE || state == RESPOND);

  // With LATENCY=1 the store is touched on the acceptance edge, so the
  // live request must be used before it lands in the holding registers.
  assign eff_idx  = accept ? req_idx           : hold_idx;
  assign eff_data = accept ? bus.mem_req.data  : hold_data;
  assign eff_rw   = accept ? bus.mem_req.rw    : hold_rw;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE, RESPOND: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESPOND;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_W'(LATENCY - 1);
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_next = RESPOND;
          cnt_next   = '0;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // A reset edge must never commit an abandoned write.
  assign store_we = enter_resp && eff_rw && !rst;
  assign store_re = enter_resp && !eff_rw && !rst;

  mem_store_downstream #(
    .LINES_LOG2 (LINES_LOG2)
  ) u_store (
    .clk   (clk),
    .we    (store_we),
    .waddr (eff_idx),
    .wdata (eff_data),
    .re    (store_re),
    .raddr (eff_idx),
    .rdata (store_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      hold_idx        <= '0;
      hold_data       <= '0;
      hold_rw         <= 1'b0;
      wr_line         <= '0;
      resp_from_store <= 1'b0;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        hold_idx  <= req_idx;
        hold_data <= bus.mem_req.data;
        hold_rw   <= bus.mem_req.rw;
      end
      if (enter_resp) begin
        if (eff_rw) begin
          wr_line         <= eff_data;
          resp_from_store <= 1'b0;
          wr_cnt          <= sat_inc16(wr_cnt);
        end else begin
          resp_from_store <= 1'b1;
          rd_cnt          <= sat_inc16(rd_cnt);
        end
      end
    end
  end

  // Read data comes straight from the store's output register, which
  // only reloads on the next read, so the response holds by itself.
  assign bus.mem_data = mem_data_type'{
    data:  (resp_from_store ? store_rdata : wr_line),
    ready: (state == RESPOND)
  };

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl_downstream.sv
// ------------------------------------------------------------------
// tb_mem_ctrl_downstream: scoreboard bench, LATENCY=4 and LATENCY=1 copies
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mem_ctrl_downstream;
  import cache_def::*;

  localparam int LAT0 = 4;
  localparam int LL0  = 12;
  localparam int LAT1 = 1;
  localparam int LL1  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_downstream_if bus0 ();
  mem_ctrl_downstream_if bus1 ();
  logic        busy0, busy1;
  logic [15:0] rd0, wr0, rd1, wr1;

  mem_ctrl_downstream #(.LATENCY(LAT0), .LINES_LOG2(LL0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .rd_cnt(rd0), .wr_cnt(wr0));
  mem_ctrl_downstream #(.LATENCY(LAT1), .LINES_LOG2(LL1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .rd_cnt(rd1), .wr_cnt(wr1));

  typedef struct {
    int           inst;
    int           acc;
    int           due;
    bit           rw;
    logic [127:0] data;
  } exp_t;

  exp_t         q[$];
  logic [127:0] store [int];
  int           cyc    = 0;
  int           checks = 0;
  int           errors = 0;
  bit           mon_en = 1'b0;
  int           mrd [2];
  int           mwr [2];
  bit           pw_v [2];
  int           pw_key [2];
  logic [127:0] pw_data [2];
  int           pw_due [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int line_key(input int i, input logic [31:0] a);
    int lines;
    lines = (i == 0) ? (1 << LL0) : (1 << LL1);
    return i * 65536 + int'((a >> 4) % lines);
  endfunction

  function automatic int sat(input int v);
    return (v < 65535) ? v + 1 : 65535;
  endfunction

  task automatic fail(input string msg);
    errors++;
    if (errors <= 40) $display("FAIL %s (cycle %0d)", msg, cyc);
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) fail($sformatf("%s: got %0h, expected %0h", nm, act, exp));
  endtask

  // A request is taken unless an earlier one is still short of its response cycle.
  function automatic void model_accept(input int i, input bit rw, input logic [31:0] a,
                                       input logic [127:0] d);
    exp_t e;
    foreach (q[j]) if (q[j].inst == i && q[j].due > cyc) return;
    if (pw_v[i]) begin
      store[pw_key[i]] = pw_data[i];
      pw_v[i] = 1'b0;
    end
    e.inst = i; e.acc = cyc; e.due = cyc + lat(i); e.rw = rw;
    if (rw) begin
      e.data = d;
      pw_v[i] = 1'b1; pw_key[i] = line_key(i, a); pw_data[i] = d; pw_due[i] = e.due;
    end else begin
      e.data = store.exists(line_key(i, a)) ? store[line_key(i, a)] : '0;
    end
    q.push_back(e);
  endfunction

  task automatic step(input int i, input bit v, input bit rw, input logic [31:0] a,
                      input logic [127:0] d);
    bus0.mem_req.valid = (i == 0) && v;
    bus1.mem_req.valid = (i == 1) && v;
    bus0.mem_req.rw = rw;  bus1.mem_req.rw = rw;
    bus0.mem_req.addr = a; bus1.mem_req.addr = a;
    bus0.mem_req.data = d; bus1.mem_req.data = d;
    if (v) model_accept(i, rw, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 1'b0, 1'b0, 32'h0, '0);
  endtask

  task automatic do_reset();
    bus0.mem_req.valid = 1'b0;
    bus1.mem_req.valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      // Writes whose response edge came before the reset edge did happen.
      if (pw_v[i] && pw_due[i] < cyc) store[pw_key[i]] = pw_data[i];
      pw_v[i] = 1'b0;
      mrd[i] = 0;
      mwr[i] = 0;
    end
    q.delete();
    check("reset_ready0", bus0.mem_data.ready, 0);
    check("reset_data0",  bus0.mem_data.data, 0);
    check("reset_busy0",  busy0, 0);
    check("reset_rd0",    rd0, 0);
    check("reset_wr0",    wr0, 0);
    check("reset_ready1", bus1.mem_data.ready, 0);
    check("reset_busy1",  busy1, 0);
    check("reset_rd1",    rd1, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        logic         rdy, bsy;
        logic [127:0] dat;
        logic [15:0]  rc, wc;
        int           k;
        bit           bexp;
        rdy = (i == 0) ? bus0.mem_data.ready : bus1.mem_data.ready;
        dat = (i == 0) ? bus0.mem_data.data  : bus1.mem_data.data;
        bsy = (i == 0) ? busy0 : busy1;
        rc  = (i == 0) ? rd0 : rd1;
        wc  = (i == 0) ? wr0 : wr1;
        bexp = 1'b0;
        k = -1;
        foreach (q[j]) begin
          if (q[j].inst == i && q[j].acc < cyc && cyc <= q[j].due) bexp = 1'b1;
          if (q[j].inst == i && k < 0) k = j;
        end
        check($sformatf("busy%0d", i), bsy, bexp);
        if (rdy) begin
          if (k < 0 || q[k].due != cyc) begin
            checks++;
            fail($sformatf("ready_timing%0d: ready at cycle %0d, expected at %0d",
                           i, cyc, (k < 0) ? -1 : q[k].due));
            if (k >= 0 && q[k].due < cyc) q.delete(k);
          end else begin
            check($sformatf("data%0d", i), dat, q[k].data);
            if (q[k].rw) mwr[i] = sat(mwr[i]);
            else         mrd[i] = sat(mrd[i]);
            check($sformatf("rd_cnt%0d", i), rc, mrd[i]);
            check($sformatf("wr_cnt%0d", i), wc, mwr[i]);
            q.delete(k);
          end
        end else if (k >= 0 && q[k].due <= cyc) begin
          checks++;
          fail($sformatf("missing_ready%0d: ready 0, expected 1 at cycle %0d", i, q[k].due));
          q.delete(k);
        end
      end
    end
  end

  initial begin
    bus0.mem_req = '0;
    bus1.mem_req = '0;
    do_reset();
    mon_en = 1'b1;

    // Single write then read-back of the same line.
    step(0, 1'b1, 1'b1, 32'h20, 128'h5);
    idle(6);
    step(0, 1'b1, 1'b0, 32'h20, '0);
    idle(6);

    // Back-to-back: next request presented in the RESPOND cycle of a write.
    step(0, 1'b1, 1'b1, 32'h40, {4{32'ha5a5_1234}});
    idle(3);
    step(0, 1'b1, 1'b0, 32'h80, '0);
    idle(6);
    step(0, 1'b1, 1'b0, 32'h40, '0);
    idle(6);

    // Requests during WAIT are dropped; alias address hits the same line.
    step(0, 1'b1, 1'b1, 32'h60, 128'h77);
    for (int n = 0; n < 3; n++) step(0, 1'b1, 1'b0, 32'h20, '0);
    idle(4);
    step(0, 1'b1, 1'b0, 32'habcd_0065, '0);
    idle(6);

    // Reset while a write is in flight: the write is lost.
    step(0, 1'b1, 1'b1, 32'h100, 128'hdead_beef);
    idle(1);
    do_reset();
    step(0, 1'b1, 1'b0, 32'h100, '0);
    idle(6);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = {16'($urandom), 8'h00, 4'($urandom_range(0, 7)), 4'($urandom)};
      step(0, ($urandom % 3) != 0, 1'($urandom), a,
           {$urandom, $urandom, $urandom, $urandom});
    end
    idle(8);

    // LATENCY=1 copy: response in the following cycle, line index wraps at 16.
    step(1, 1'b1, 1'b1, 32'h30, 128'h7);
    step(1, 1'b1, 1'b0, 32'h130, '0);
    idle(3);
    for (int n = 0; n < 200; n++) begin
      step(1, ($urandom % 3) != 0, 1'($urandom), $urandom,
           {$urandom, $urandom, $urandom, $urandom});
    end
    idle(4);

    // Saturation of rd_cnt: 65536 back-to-back reads.
    do_reset();
    for (int n = 0; n < 65536; n++) step(1, 1'b1, 1'b0, $urandom, '0);
    idle(8);

    foreach (q[j]) begin
      checks++;
      fail($sformatf("leftover%0d: response due at cycle %0d never seen", q[j].inst, q[j].due));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_ctrl_downstream.md
MEM_CTRL_DOWNSTREAM -- requirements
Module: mem_ctrl_downstream

Interface
REQ-001 SHALL have parameter LATENCY, default 4, giving cycles from request acceptance to response (legal range 1..15).
REQ-002 SHALL have parameter LINES_LOG2, default 12, giving backing store depth 2**LINES_LOG2 lines of cache_data_type (128 bits).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_req  input  mem_req_type  cache-to-memory request: addr, data (128), rw (1 = write), valid.
REQ-006 SHALL have port mem_data  output  mem_data_type  memory-to-cache response: data (128), ready.
REQ-007 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-008 SHALL have port rd_cnt  output  16  count of completed reads.
REQ-009 SHALL have port wr_cnt  output  16  count of completed writes.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT, RESPOND.
REQ-011 SHALL, in IDLE or RESPOND with mem_req.valid=1, capture addr, data and rw into holding registers (acceptance edge T).
REQ-012 SHALL, after acceptance, go to WAIT with down-counter = LATENCY-1, or directly to RESPOND if LATENCY=1.
REQ-013 SHALL, in WAIT, decrement the counter each cycle and move to RESPOND on the edge where it reaches 0; ready is therefore high in the cycle after edge T+LATENCY-1.
REQ-014 SHALL index the store by captured addr[LINES_LOG2+3:4]; addr[3:0] and upper bits are ignored.
REQ-015 SHALL, on the edge entering RESPOND, write the captured data to the store when rw=1; otherwise load the store line into the response register.
REQ-016 SHALL drive mem_data.ready=1 for exactly one cycle, in RESPOND; ready is 0 in every other state.
REQ-017 SHALL drive mem_data.data = read line on reads and = written line on writes; the value holds until the next response.
REQ-018 SHALL ignore mem_req.valid during WAIT (no queueing, no error).
REQ-019 SHALL, in RESPOND without valid, return to IDLE; with valid, accept the new request (back-to-back write-back then allocate) per REQ-011.
REQ-020 SHALL make a read following a write to the same line return the newly written data.
REQ-021 SHALL increment rd_cnt or wr_cnt on the edge entering RESPOND, saturating at 16'hffff.

Reset
REQ-022 SHALL, on rst=1 at posedge, set state IDLE, counter 0, mem_data.ready 0, mem_data.data 0, busy 0, rd_cnt 0, wr_cnt 0.
REQ-023 SHALL abandon an in-flight request on reset; a pending write is not performed.
REQ-024 SHALL NOT clear store contents on reset; the store is zero-initialised at elaboration only.

Structure
REQ-025 SHALL take mem_req_type, mem_data_type and cache_data_type from cache_def; no new shared typedefs.
REQ-026 SHALL place the backing array in one sub-module, mem_store_downstream (1 write port, 1 registered read port).
REQ-027 SHALL keep LATENCY and LINES_LOG2 local to the module as parameters, not in cache_def.

Verification
REQ-028 SHALL cover: LATENCY=4; write addr 0x20, data 0x...0005, valid at T -> ready high only in cycle T+4; wr_cnt=1.
REQ-029 SHALL cover: after REQ-028, read addr 0x20 -> ready 4 cycles later with data 0x...0005; rd_cnt=1.
REQ-030 SHALL cover: write 0x40 completes with valid+rw=0 addr 0x80 in the RESPOND cycle -> second ready exactly 4 cycles later, no IDLE cycle between.
REQ-031 SHALL cover: valid pulses during WAIT -> ignored, one ready only, counters change by 1.
REQ-032 SHALL cover: rst asserted 2 cycles after a write to 0x100 is accepted -> no ready; later read of 0x100 returns 0.
REQ-033 SHALL cover: LATENCY=1 -> ready in cycle after acceptance; rd_cnt forced to 16'hfffe, two reads -> 16'hffff held.
